// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK levels, R/W bit values and the
// address-match helper. Used by both the target and the companion master.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE_DATA,
        WRITE_ACK,
        READ_DATA,
        READ_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // The general-call address (0) never matches, even if it is configured as our own.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own);
        return (addr_byte[7:1] == own) && (addr_byte[7:1] != 7'h00);
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: 2-FF synchronizer, stability filter and 1-cycle rise/fall strobes.
// The filtered line and its history reset to 1, which is the idle level of the bus.
module i2c_line_filter #(
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic filt,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] FC = 4'(FILTER_CYCLES);

    logic [1:0] sync;
    logic       last;
    logic [3:0] cnt;
    logic       filt_prev;

    // NOTE: every register here is written with <= so that all of them update from the
    // values present before the clock edge, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= 2'b11;
            last      <= 1'b1;
            cnt       <= 4'd0;
            filt      <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            sync <= {sync[0], line};
            last <= sync[1];
            // cnt is the length of the current run of equal samples, saturating at FC.
            if (sync[1] != last) begin
                cnt <= 4'd1;
            end else if (cnt != FC) begin
                cnt <= cnt + 4'd1;
            end
            if (cnt == FC) begin
                filt <= last;
            end
            filt_prev <= filt;
        end
    end

    assign rise = filt & ~filt_prev;
    assign fall = ~filt & filt_prev;

endmodule

// File: rtl/i2c_slave.sv
// 7-bit I2C target: filters SCL/SDA, detects START/STOP, matches its own address and
// moves bytes between the bus and user logic. SDA is only ever pulled low or released.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR    = 7'h68,
    parameter int         FILTER_CYCLES = 3
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] rx_data_out,
    output logic       rx_valid_out,
    input  logic       ack_en_in,
    input  logic [7:0] tx_data_in,
    output logic       tx_req_out,
    output logic       rd_wr_out,
    output logic       busy_out,
    output logic       start_out,
    output logic       stop_out
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
        .clk  (clk_in),
        .rst  (rst),
        .line (SCL),
        .filt (scl_f),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
        .clk  (clk_in),
        .rst  (rst),
        .line (SDA),
        .filt (sda_f),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    i2c_state_t state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] rx_data, rx_data_n;
    logic       sda_low, sda_low_n;
    logic       busy, busy_n;
    logic       rd_wr, rd_wr_n;
    // Second half of an acknowledge slot: our ACK is on the bus, or a tx byte is pending.
    logic       ack_phase, ack_phase_n;
    logic       rx_valid, rx_valid_n;
    logic       tx_req, tx_req_n;
    logic       start_p, start_n;
    logic       stop_p, stop_n;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            sda_low   <= 1'b0;
            busy      <= 1'b0;
            rd_wr     <= 1'b0;
            ack_phase <= 1'b0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            start_p   <= 1'b0;
            stop_p    <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            rx_data   <= rx_data_n;
            sda_low   <= sda_low_n;
            busy      <= busy_n;
            rd_wr     <= rd_wr_n;
            ack_phase <= ack_phase_n;
            rx_valid  <= rx_valid_n;
            tx_req    <= tx_req_n;
            start_p   <= start_n;
            stop_p    <= stop_n;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one
        // unassigned and no latch is inferred.
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        rx_data_n   = rx_data;
        sda_low_n   = sda_low;
        busy_n      = busy;
        rd_wr_n     = rd_wr;
        ack_phase_n = ack_phase;
        rx_valid_n  = 1'b0;
        tx_req_n    = 1'b0;
        start_n     = 1'b0;
        stop_n      = 1'b0;

        if (stop_det) begin
            stop_n    = 1'b1;
            sda_low_n = 1'b0;
            busy_n    = 1'b0;
            state_n   = IDLE;
        end else if (start_det) begin
            start_n   = 1'b1;
            sda_low_n = 1'b0;
            busy_n    = 1'b0;
            bit_cnt_n = 3'd0;
            state_n   = ADDR;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda_f};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (addr_match(shift_n, SLAVE_ADDR)) begin
                                rd_wr_n     = shift_n[0];
                                ack_phase_n = 1'b0;
                                state_n     = ADDR_ACK;
                            end else begin
                                state_n = WAIT_STOP;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_low_n   = 1'b1;
                            busy_n      = 1'b1;
                            ack_phase_n = 1'b1;
                        end else begin
                            bit_cnt_n = 3'd0;
                            if (rd_wr == RW_READ) begin
                                shift_n   = tx_data_in;
                                sda_low_n = ~tx_data_in[7];
                                state_n   = READ_DATA;
                            end else begin
                                sda_low_n = 1'b0;
                                state_n   = WRITE_DATA;
                            end
                        end
                    end else if (scl_rise && ack_phase && rd_wr == RW_READ) begin
                        tx_req_n = 1'b1;
                    end
                end
                WRITE_DATA: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda_f};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_n   = shift_n;
                            rx_valid_n  = 1'b1;
                            ack_phase_n = 1'b0;
                            state_n     = WRITE_ACK;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_low_n   = ack_en_in;
                            ack_phase_n = 1'b1;
                        end else begin
                            sda_low_n = 1'b0;
                            state_n   = WRITE_DATA;
                        end
                    end
                end
                READ_DATA: begin
                    // Bit 7 went out on entry; shift[6] is always the next bit to drive.
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_low_n   = 1'b0;
                            bit_cnt_n   = 3'd0;
                            ack_phase_n = 1'b0;
                            state_n     = READ_ACK;
                        end else begin
                            sda_low_n = ~shift[6];
                            shift_n   = {shift[6:0], 1'b0};
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise && !ack_phase) begin
                        if (sda_f == ACK) begin
                            tx_req_n    = 1'b1;
                            ack_phase_n = 1'b1;
                        end else begin
                            sda_low_n = 1'b0;
                            state_n   = WAIT_STOP;
                        end
                    end else if (scl_fall && ack_phase) begin
                        shift_n   = tx_data_in;
                        sda_low_n = ~tx_data_in[7];
                        bit_cnt_n = 3'd0;
                        state_n   = READ_DATA;
                    end
                end
                WAIT_STOP: sda_low_n = 1'b0;
                default:   state_n   = IDLE;
            endcase
        end
    end

    assign SDA          = sda_low ? 1'b0 : 1'bz;
    assign rx_data_out  = rx_data;
    assign rx_valid_out = rx_valid;
    assign tx_req_out   = tx_req;
    assign rd_wr_out    = rd_wr;
    assign busy_out     = busy;
    assign start_out    = start_p;
    assign stop_out     = stop_p;

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (responder) for the 7-bit-address, standard/fast-mode bus driven by our I2C master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches its own address, ACKs, and moves bytes.
- Byte-level handshakes: received bytes go out to user logic; user logic supplies transmit bytes.
- Intended for loopback verification of the master and for FPGA-side sensor emulation (MPU6050-like target). No clock stretching.

Parameters:
- SLAVE_ADDR, 7'h68, own 7-bit address.
- FILTER_CYCLES, 3, consecutive equal synchronized samples required before a filtered line changes (range 1..15).

Ports:
- clk_in  in  1  system clock; must be at least 20x the SCL frequency.
- rst  in  1  asynchronous, active-high reset.
- SCL  in  1  bus clock, observed only.
- SDA  inout  1  open-drain data; the block drives 0 or Z only.
- rx_data_out  out  8  last byte written by the master.
- rx_valid_out  out  1  1-cycle pulse when rx_data_out updates.
- ack_en_in  in  1  when 1, ACK written data bytes; when 0, NACK them.
- tx_data_in  in  8  next byte to send to the master.
- tx_req_out  out  1  1-cycle pulse requesting the next tx byte.
- rd_wr_out  out  1  R/W bit of the current addressed transfer.
- busy_out  out  1  high while addressed, i.e. from address ACK until STOP or repeated START.
- start_out  out  1  1-cycle pulse on START or repeated START.
- stop_out  out  1  1-cycle pulse on STOP.

Behaviour:
- Reset: state IDLE. All outputs 0. rx_data_out=0. SDA released (Z). Filtered lines reset to 1.
- Input path: each line goes through a 2-FF synchronizer, then the FILTER_CYCLES stability filter. Edge detection runs on the filtered signals (rise/fall strobes, 1 cycle).
- START (filtered SDA fall while filtered SCL=1), from any state:
  - pulse start_out, release SDA, bit_cnt=0, state=ADDR.
  - If busy_out was 1, clear it.
- STOP (filtered SDA rise while filtered SCL=1), from any state:
  - pulse stop_out, release SDA, busy_out=0, state=IDLE.
  - If START and STOP would both be flagged in one cycle, STOP wins.
- Sampling and driving:
  - SDA is sampled on the filtered SCL rising strobe.
  - The slave changes its SDA drive only on the cycle after the filtered SCL falling strobe. The sync+filter delay provides the hold time.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits MSB first on rising strobes. After the 8th:
    - if bits[7:1]==SLAVE_ADDR: latch rd_wr_out=bit0, go to ADDR_ACK;
    - otherwise go to WAIT_STOP.
  - ADDR_ACK:
    - Next falling strobe: drive SDA=0, busy_out=1.
    - Following rising strobe: if rd_wr_out=1, pulse tx_req_out.
    - Following falling strobe: if rd_wr_out=1, load shift=tx_data_in, drive bit7, go to READ_DATA; else release SDA, go to WRITE_DATA.
  - WRITE_DATA: shift in 8 bits on rising strobes. On the 8th, rx_data_out=byte and pulse rx_valid_out in the same cycle, then go to WRITE_ACK.
  - WRITE_ACK:
    - Next falling strobe: drive SDA=0 if ack_en_in else release. ack_en_in is sampled at that strobe.
    - Following falling strobe: release SDA, go to WRITE_DATA.
  - READ_DATA:
    - Falling strobes 2..8 drive bits 6..0; a 0 bit drives low, a 1 bit releases.
    - The 9th falling strobe releases SDA and moves to READ_ACK.
  - READ_ACK: sample the master's ACK on the rising strobe.
    - 0 (ACK): pulse tx_req_out. At the next falling strobe, load tx_data_in and drive its bit7, go to READ_DATA.
    - 1 (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: SDA released; wait for STOP (to IDLE) or START (to ADDR).
- Counters:
  - bit_cnt is 3 bits, wraps 7->0 at each byte boundary.
  - The filter counter saturates at FILTER_CYCLES.
- tx_data_in latency: it must be valid within half an SCL period of the tx_req_out pulse; it is sampled exactly at the falling strobe.
- Writes have no backpressure: rx_data_out is overwritten on each byte.
- General call (address 0) is ignored, i.e. treated as a mismatch.

Decomposition:
- Package i2c_pkg: state enum (IDLE, ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK, WAIT_STOP), ACK=1'b0 and NACK=1'b1 constants, R/W bit constants. Shared with the master.
- Sub-module i2c_line_filter (synchronizer + stability filter + rise/fall strobes), instantiated once for SCL and once for SDA.

Test Plan:
- Write, single byte:
  - Stimulus: master writes 0xA5 to address 0x68, ack_en_in=1.
  - Response: start_out pulse; SDA=0 during the address ACK and data ACK; rx_data_out=0xA5 with one rx_valid_out pulse; stop_out pulse; busy_out 1 -> 0.
- Read, multi-byte:
  - Stimulus: master reads 3 bytes from 0x68; tx_data_in returns 0x11, 0x22, 0x33 on each tx_req_out.
  - Response: master receives 11/22/33; exactly 3 tx_req_out pulses; master NACKs the last byte, then slave goes to WAIT_STOP and SDA released.
- Address mismatch:
  - Stimulus: master addresses 0x50.
  - Response: SDA never driven low; busy_out stays 0; no rx_valid_out/tx_req_out; master sees NACK and retries.
- Repeated START:
  - Stimulus: write register pointer 0x3B, repeated START, read 2 bytes.
  - Response: two start_out pulses; rd_wr_out 0 then 1; rx_data_out=0x3B; 2 tx_req_out pulses.
- Data NACK and glitch filtering:
  - Stimulus: ack_en_in=0 during a write; separately, a 1-cycle SCL glitch is injected.
  - Response: SDA released at the data ACK bit; the glitch produces no bit shift.
- Mid-transfer reset:
  - Stimulus: assert rst during a read at bit 4.
  - Response: SDA immediately Z and all outputs 0; the next START plus address is handled normally.
